// File: rtl/obi_stall_pkg.sv
// obi_stall_pkg: shared types and constants for the OBI stall buffer
package obi_stall_pkg;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  // widest response delay a FIFO entry can hold; RSP_STALL_BITS must not exceed it
  localparam int DELAY_W = 8;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;
  typedef struct packed {
    logic [31:0]        rdata;
    logic [DELAY_W-1:0] delay;
  } rsp_entry_t;
  typedef enum logic {IDLE, STALL} fsm_state_t;
endpackage

// File: rtl/obi_stall_lfsr.sv
// obi_stall_lfsr: 16-bit Fibonacci LFSR exposing the grant and response stall fields
module obi_stall_lfsr
  import obi_stall_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int GNT_BITS = 3,
  parameter int RSP_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  output logic [GNT_BITS-1:0] gnt_bits,
  output logic [RSP_BITS-1:0] rsp_bits
);
  logic [15:0] state;
  always_ff @(posedge clk) state <= rst ? SEED : {state[14:0], ^(state & LFSR_TAPS)};
  assign gnt_bits = state[GNT_BITS-1:0];
  assign rsp_bits = state[15 -: RSP_BITS];
endmodule

// File: rtl/obi_stall_buffer.sv
// obi_stall_buffer: OBI pass-through that injects random grant stalls and response latency
module obi_stall_buffer
  import obi_stall_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GNT_STALL_BITS = 3,
  parameter int RSP_STALL_BITS = 3,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_en_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        req_o,
  input  logic        gnt_i,
  output logic [31:0] addr_o,
  output logic        we_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  output logic        protocol_err_o,
  output logic        overflow_err_o
);
  localparam int AW = $clog2(DEPTH);
  logic [GNT_STALL_BITS-1:0] gnt_bits, gnt_stall, gcnt, gcnt_n;
  logic [RSP_STALL_BITS-1:0] rsp_bits, rsp_stall;
  fsm_state_t state, state_n;
  logic [AW:0] outstanding, count;
  logic [AW-1:0] wptr, rptr;
  rsp_entry_t mem [DEPTH];
  logic [DELAY_W-1:0] rcnt;
  obi_req_t cur, prev;
  logic prev_pend, room, empty, full, bypass, pop, push;

  obi_stall_lfsr #(.SEED(SEED), .GNT_BITS(GNT_STALL_BITS), .RSP_BITS(RSP_STALL_BITS)) u_lfsr (
    .clk(clk_i), .rst(rst_i), .gnt_bits(gnt_bits), .rsp_bits(rsp_bits)
  );

  assign gnt_stall = stall_en_i ? gnt_bits : '0;
  assign rsp_stall = stall_en_i ? rsp_bits : '0;
  assign {addr_o, we_o, be_o, wdata_o} = {addr_i, we_i, be_i, wdata_i};
  assign cur = {addr_i, we_i, be_i, wdata_i};
  assign room = outstanding < (AW+1)'(DEPTH);

  always_comb begin
    state_n = state;
    gcnt_n = gcnt;
    req_o = 1'b0;
    if (state == IDLE) begin
      if (req_i && gnt_stall == '0) req_o = room;
      else if (req_i) begin
        state_n = STALL;
        gcnt_n = gnt_stall - GNT_STALL_BITS'(1);
      end
    end else if (!req_i) state_n = IDLE;
    else if (gcnt != '0) gcnt_n = gcnt - GNT_STALL_BITS'(1);
    else begin
      req_o = room;
      state_n = (gnt_i && room) ? IDLE : STALL;
    end
  end

  assign gnt_o = req_o & gnt_i;

  // a response may bypass only an empty FIFO, so it can never overtake queued entries
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign pop = !empty && rcnt == '0;
  assign bypass = empty && rvalid_i && rsp_stall == '0;
  assign push = rvalid_i && !bypass && (!full || pop);
  assign rvalid_o = bypass || pop;
  assign rdata_o = bypass ? rdata_i : pop ? mem[rptr].rdata : '0;

  always_ff @(posedge clk_i)
    if (push) mem[wptr] <= '{rdata: rdata_i, delay: DELAY_W'(rsp_stall)};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      gcnt <= '0;
      outstanding <= '0;
      count <= '0;
      wptr <= '0;
      rptr <= '0;
      rcnt <= '0;
      prev_pend <= 1'b0;
      prev <= '0;
      protocol_err_o <= 1'b0;
      overflow_err_o <= 1'b0;
    end else begin
      state <= state_n;
      gcnt <= gcnt_n;
      outstanding <= outstanding + (AW+1)'(gnt_o) - (AW+1)'(rvalid_o && outstanding != '0);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      wptr <= wptr + AW'(push);
      rptr <= rptr + AW'(pop);
      if (push && empty) rcnt <= DELAY_W'(rsp_stall);
      else if (pop && count > (AW+1)'(1)) rcnt <= mem[rptr + AW'(1)].delay;
      else if (pop && push) rcnt <= DELAY_W'(rsp_stall);
      else if (rcnt != '0) rcnt <= rcnt - DELAY_W'(1);
      prev_pend <= req_i && !gnt_o;
      prev <= cur;
      protocol_err_o <= protocol_err_o | (prev_pend && (!req_i || cur != prev))
                        | (rvalid_o && outstanding == '0);
      overflow_err_o <= overflow_err_o | (rvalid_i && full && !pop);
    end
  end
endmodule

// File: tb/tb_obi_stall_buffer.sv
// tb_obi_stall_buffer: directed checks of pass-through, stalls, FIFO and error flags
module tb_obi_stall_buffer;
  logic clk_i = 1'b0, rst_i, stall_en_i, req_i, gnt_o, we_i, rvalid_o, req_o, gnt_i;
  logic we_o, rvalid_i, protocol_err_o, overflow_err_o;
  logic [31:0] addr_i, wdata_i, rdata_o, addr_o, wdata_o, rdata_i;
  logic [3:0] be_i, be_o;
  logic [15:0] m;
  int n_checks = 0, n_fail = 0;

  obi_stall_buffer dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_en_i(stall_en_i), .req_i(req_i), .gnt_o(gnt_o),
    .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o), .we_o(we_o),
    .be_o(be_o), .wdata_o(wdata_o), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
    .protocol_err_o(protocol_err_o), .overflow_err_o(overflow_err_o)
  );

  always #5 clk_i = ~clk_i;

  // reference LFSR: taps 16,14,13,11
  always @(posedge clk_i) m <= rst_i ? 16'hACE1 : {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  task automatic idle();
    {stall_en_i, req_i, gnt_i, rvalid_i} = '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"}, gnt_o, 0);
    check({tag, "_req"}, req_o, 0);
    check({tag, "_rvalid"}, rvalid_o, 0);
    check({tag, "_rdata"}, rdata_o, 0);
    check({tag, "_perr"}, protocol_err_o, 0);
    check({tag, "_ovf"}, overflow_err_o, 0);
  endtask

  // waits for the cycle whose response stall field is 7 so the first push is held in the FIFO
  task automatic wait_slow_slot();
    int k = 0;
    while (m[15:13] != 3'd7 && k < 200) begin
      step();
      k++;
    end
    check("slot_wait", k < 200, 1);
  endtask

  initial begin
    int k, s, d;
    logic [31:0] want;
    {rst_i, stall_en_i, req_i, addr_i, we_i, be_i, wdata_i, gnt_i, rvalid_i, rdata_i} = '0;
    step();
    do_reset();
    sample();
    check_zero("reset");
    step();

    // transparent mode: back-to-back reads, responses one cycle after grant
    gnt_i = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      req_i = i < 8;
      addr_i = 32'h1000 + 32'(i * 4);
      rvalid_i = i > 0;
      rdata_i = 32'hA000 + 32'(i);
      sample();
      if (i < 8) check("b2b_gnt", gnt_o, 1);
      if (i < 8) check("b2b_addr", addr_o, 32'h1000 + 32'(i * 4));
      if (i > 0) check("b2b_rvalid", rvalid_o, 1);
      if (i > 0) check("b2b_rdata", rdata_o, 32'hA000 + 32'(i));
      step();
    end
    idle();
    sample();
    check("b2b_perr", protocol_err_o, 0);
    check("b2b_ovf", overflow_err_o, 0);
    step();

    // outstanding limit: memory grants but withholds responses
    req_i = 1'b1;
    gnt_i = 1'b1;
    addr_i = 32'h200;
    for (int i = 0; i < 6; i++) begin
      sample();
      check("depth_gnt", gnt_o, i < 4);
      check("depth_req", req_o, i < 4);
      step();
    end
    rvalid_i = 1'b1;
    rdata_i = 32'hD0;
    sample();
    check("depth_rv", rvalid_o, 1);
    check("depth_gnt_same", gnt_o, 0);
    step();
    rvalid_i = 1'b0;
    sample();
    check("depth_regnt", gnt_o, 1);
    step();
    req_i = 1'b0;
    rvalid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rdata_i = 32'hD1 + 32'(i);
      sample();
      check("depth_drain", rvalid_o, 1);
      check("depth_drain_data", rdata_o, 32'hD1 + 32'(i));
      step();
    end
    idle();
    sample();
    check("depth_perr", protocol_err_o, 0);
    step();

    // full FIFO with simultaneous push and pop across pointer wrap
    req_i = 1'b1;
    gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("full_grant", gnt_o, 1);
      step();
    end
    idle();
    wait_slow_slot();
    stall_en_i = 1'b1;
    rvalid_i = 1'b1;
    rdata_i = 32'd1;
    sample();
    check("full_push1", rvalid_o, 0);
    step();
    stall_en_i = 1'b0;
    for (int j = 2; j <= 4; j++) begin
      rdata_i = 32'(j);
      sample();
      check("full_push", rvalid_o, 0);
      step();
    end
    rvalid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("full_hold", rvalid_o, 0);
      step();
    end
    rvalid_i = 1'b1;
    rdata_i = 32'd5;
    sample();
    check("full_pp_rv", rvalid_o, 1);
    check("full_pp_data", rdata_o, 1);
    check("full_pp_ovf", overflow_err_o, 0);
    step();
    rvalid_i = 1'b0;
    req_i = 1'b1;
    gnt_i = 1'b1;
    for (int j = 2; j <= 5; j++) begin
      sample();
      check("full_order_rv", rvalid_o, 1);
      check("full_order_data", rdata_o, 32'(j));
      if (j == 2) check("full_gnt", gnt_o, 1);
      step();
      idle();
    end
    sample();
    check("full_empty", rvalid_o, 0);
    check("full_ovf", overflow_err_o, 0);
    check("full_perr", protocol_err_o, 0);
    step();

    // payload change while request pending is a sticky protocol error
    req_i = 1'b1;
    gnt_i = 1'b0;
    addr_i = 32'h100;
    sample();
    check("perr_before", protocol_err_o, 0);
    step();
    addr_i = 32'h104;
    sample();
    check("perr_same_cycle", protocol_err_o, 0);
    step();
    req_i = 1'b0;
    sample();
    check("perr_set", protocol_err_o, 1);
    step();
    step();
    step();
    sample();
    check("perr_sticky", protocol_err_o, 1);
    step();
    do_reset();
    sample();
    check("perr_cleared", protocol_err_o, 0);
    step();

    // reset with three queued responses discards them
    req_i = 1'b1;
    gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    idle();
    wait_slow_slot();
    stall_en_i = 1'b1;
    rvalid_i = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      rdata_i = 32'hE0 + 32'(j);
      step();
      stall_en_i = 1'b0;
    end
    idle();
    do_reset();
    sample();
    check_zero("rst_mid");
    for (int i = 0; i < 8; i++) begin
      step();
      sample();
      check("rst_discard", rvalid_o, 0);
    end
    step();
    req_i = 1'b1;
    gnt_i = 1'b1;
    addr_i = 32'h300;
    sample();
    check("rst_post_gnt", gnt_o, 1);
    step();
    req_i = 1'b0;
    rvalid_i = 1'b1;
    rdata_i = 32'hBEEF;
    sample();
    check("rst_post_rv", rvalid_o, 1);
    check("rst_post_data", rdata_o, 32'hBEEF);
    step();
    idle();
    sample();
    check("rst_post_perr", protocol_err_o, 0);
    step();

    // random stalls checked against the reference LFSR, one transaction at a time
    stall_en_i = 1'b1;
    gnt_i = 1'b1;
    for (int t = 0; t < 200; t++) begin
      repeat ($urandom_range(0, 2)) step();
      req_i = 1'b1;
      addr_i = $urandom;
      we_i = 1'($urandom);
      be_i = 4'($urandom);
      wdata_i = $urandom;
      s = int'(m[2:0]);
      k = 0;
      sample();
      while (!gnt_o && k < 20) begin
        step();
        sample();
        k++;
      end
      check("rnd_gnt_lat", k, s);
      step();
      req_i = 1'b0;
      rvalid_i = 1'b1;
      rdata_i = $urandom;
      want = rdata_i;
      d = int'(m[15:13]);
      k = 0;
      sample();
      while (!rvalid_o && k < 20) begin
        step();
        rvalid_i = 1'b0;
        sample();
        k++;
      end
      check("rnd_rsp_lat", k, d == 0 ? 0 : d + 1);
      check("rnd_rdata", rdata_o, want);
      step();
      rvalid_i = 1'b0;
    end
    idle();
    sample();
    check("rnd_perr", protocol_err_o, 0);
    check("rnd_ovf", overflow_err_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
